// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: line-state encoding and 8N1 frame constants,
// common to the transmitter and the receiver.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned symbol_edge_time(input int unsigned clk_hz,
                                                     input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-push handshake into the transmitter: producer drives data/valid,
// transmitter answers with ready.
interface uart_transmitter_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (output data_in, output data_in_valid, input data_in_ready);
    modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter_fifo.sv
// First-word-fall-through byte buffer with registered full/empty flags.
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap; the
    // extra MSB separates full (MSBs differ) from empty (pointers equal).
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO feeding a bit-timed line FSM with a
// registered serial output.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_transmitter_if.slave   bus,
    output logic                serial_out,
    output logic                tx_busy
);
    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W    = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_out_q, serial_out_d;
    logic             tx_busy_q, tx_busy_d;
    logic             pop, last_sym, line_bit;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_data;

    assign bus.data_in_ready = !fifo_full && !rst;

    fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.data_in_valid && bus.data_in_ready),
        .wr_data (bus.data_in),
        .pop     (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        last_sym  = (sym_cnt_q == LAST_SYM);
        line_bit  = STOP_BIT;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_data;
                    sym_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                line_bit  = START_BIT;
                sym_cnt_d = last_sym ? '0 : sym_cnt_q + CNT_W'(1);
                if (last_sym) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                line_bit  = shift_q[0];
                sym_cnt_d = last_sym ? '0 : sym_cnt_q + CNT_W'(1);
                if (last_sym) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                sym_cnt_d = last_sym ? '0 : sym_cnt_q + CNT_W'(1);
                // Chain straight into the next start bit so frames abut.
                if (last_sym) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs trail the state by one register stage.
        serial_out_d = line_bit;
        tx_busy_d    = (state_q != IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sym_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            serial_out_q <= 1'b1;
            tx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            serial_out_q <= serial_out_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

    assign serial_out = serial_out_q;
    assign tx_busy    = tx_busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 10 clocks per bit; a per-cycle
// expected-line queue is compared against serial_out and tx_busy.
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_out, tx_busy;
    int   checks = 0;
    int   errors = 0;
    logic exp_line[$];

    uart_transmitter_if bus();

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .serial_out (serial_out),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 10; i++) exp_line.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 10; i++) exp_line.push_back(b[k]);
        for (int i = 0; i < 10; i++) exp_line.push_back(1'b1);
    endtask

    // One clock: apply inputs, optionally check ready, then check the line after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic chk_rdy, input logic exp_rdy);
        logic exp_s, exp_b;
        rst = r;
        bus.data_in_valid = v;
        bus.data_in = d;
        #1;
        if (chk_rdy) check("data_in_ready", bus.data_in_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (r) begin
            exp_line.delete();
            exp_s = 1'b1;
            exp_b = 1'b0;
        end else begin
            exp_b = (exp_line.size() != 0);
            exp_s = (exp_line.size() != 0) ? exp_line.pop_front() : 1'b1;
        end
        check("serial_out", serial_out, exp_s);
        check("tx_busy", tx_busy, exp_b);
        if (!r && v && chk_rdy && exp_rdy) begin
            if (exp_line.size() == 0) exp_line.push_back(1'b1);
            push_frame(d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic drain(input int bound);
        int i;
        i = 0;
        while (exp_line.size() != 0 && i < bound) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            i++;
        end
        check("drain_timeout", exp_line.size(), 0);
        idle(3);
    endtask

    initial begin
        logic [7:0] bytes6 [6];
        int idx, busy_cnt, low_cnt;
        bus.data_in_valid = 1'b0;
        bus.data_in = 8'h00;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Single byte 0xA5: 101 busy cycles, start + four zero bits low
        step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
        busy_cnt = 0;
        low_cnt = 0;
        for (int i = 0; i < 110; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            if (tx_busy) busy_cnt++;
            if (!serial_out) low_cnt++;
        end
        check("a5_busy_cycles", busy_cnt, 101);
        check("a5_low_cycles", low_cnt, 50);
        check("a5_drained", exp_line.size(), 0);

        // Back-to-back 0x00, 0xFF, 0x55
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        drain(400);

        // FIFO full with valid held for six bytes
        bytes6[0] = 8'h11; bytes6[1] = 8'h22; bytes6[2] = 8'h33;
        bytes6[3] = 8'h44; bytes6[4] = 8'h5A; bytes6[5] = 8'hC3;
        idx = 0;
        for (int k = 0; k < 110; k++) begin
            logic v, er;
            v = (idx < 6);
            er = (k < 5) || (k == 102);
            step(1'b0, v, v ? bytes6[idx] : 8'h00, (k <= 102), er);
            if (v && er) idx++;
        end
        check("full_accepts", idx, 6);
        drain(700);

        // Push coinciding with the STOP->START pop, two bytes queued
        step(1'b0, 1'b1, 8'h81, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h24, 1'b1, 1'b1);
        for (int k = 3; k < 101; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        drain(500);

        // Reset during DATA of 0x3C with two bytes queued
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
        for (int k = 3; k < 40; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, core clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 4, byte-buffer entries; power of two, >=2.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 data_in  input  8  byte to transmit.
REQ-008 data_in_valid  input  1  data_in is valid.
REQ-009 data_in_ready  output  1  block accepts data_in this cycle.
REQ-010 serial_out  output  1  UART line, idle high.
REQ-011 tx_busy  output  1  a frame is on the line or the FIFO is non-empty.

Function
REQ-012 SYMBOL_EDGE_TIME SHALL equal CLOCK_FREQ/BAUD_RATE (integer divide); the bit counter width SHALL be $clog2(SYMBOL_EDGE_TIME).
REQ-013 A byte SHALL be accepted on a rising edge where data_in_valid && data_in_ready; data_in_ready SHALL be high iff the FIFO is not full and rst is low.
REQ-014 Frame format SHALL be 8N1: one start bit (0), data bits LSB first, one stop bit (1); each bit held exactly SYMBOL_EDGE_TIME cycles.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP: IDLE->START when the FIFO is non-empty (pop); START->DATA after one bit time; DATA->STOP after 8 bit times; STOP->START on the last stop-bit cycle if the FIFO is non-empty, else STOP->IDLE.
REQ-016 serial_out SHALL be registered and SHALL be high in IDLE and STOP.
REQ-017 Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge N SHALL drive the start bit on serial_out from edge N+2.
REQ-018 Back-to-back frames SHALL have no idle gap: the next start bit follows the last stop-bit cycle directly.
REQ-019 Simultaneous push and pop in one cycle SHALL be supported; occupancy is unchanged.
REQ-020 When the FIFO is full, data_in_ready SHALL be low and data_in SHALL be ignored; no byte is overwritten or dropped.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-022 tx_busy SHALL be low only in IDLE with the FIFO empty.
REQ-023 Bytes SHALL be transmitted in acceptance order.

Reset
REQ-024 On any edge with rst high: FSM=IDLE, FIFO emptied, bit and symbol counters zeroed, serial_out=1, tx_busy=0, data_in_ready=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; serial_out SHALL be high from the next edge. Queued bytes SHALL be discarded.
REQ-026 data_in_ready SHALL go high on the first cycle after rst deasserts.

Structure
REQ-027 FSM state encoding and the 8N1 frame constants (start=0, stop=1, 8 data bits) SHALL live in the shared uart package used by the receiver.
REQ-028 The byte buffer SHALL be a separate sub-module named fifo, parameterised by WIDTH=8 and DEPTH=FIFO_DEPTH, with registered full/empty flags.
REQ-029 The transmitter top SHALL contain only the FSM, the counters, the shift register and the fifo instance.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so 10 cycles/bit and 100 cycles/frame)
REQ-030 Single byte: push 0xA5 at edge N -> serial_out low from N+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1 (10 cycles each), then high; tx_busy drops at N+102.
REQ-031 Back-to-back: push 0x00, 0xFF, 0x55 on consecutive edges -> three contiguous 100-cycle frames with no high gap between the stop bit and the next start bit.
REQ-032 Full: hold valid high with 6 bytes while idle -> data_in_ready drops after 5 accepts (4 queued plus 1 popped); the remaining byte is accepted only after the next pop; all bytes are sent in order.
REQ-033 Reset mid-frame: assert rst for 1 cycle during DATA of 0x3C with 2 bytes queued -> serial_out=1 the next cycle, tx_busy=0, and no further frames are sent.
REQ-034 Simultaneous push and pop: FIFO holds 2 bytes, push at the edge of a STOP->START pop -> occupancy stays 2 and data_in_ready stays high.
REQ-035 Loopback: connect serial_out to the codebase UART receiver and send 0x00..0xFF -> the receiver outputs an identical byte sequence.
